// File: rtl/fp_add7_unit.sv
// ============================================================================
//  Module   : fp_add7_unit
//  Purpose  : Single-precision (IEEE-754 binary32) adder with a fixed
//             LATENCY-edge pipeline and a load/busy/done handshake.
//             Round-to-nearest-even, denormals flushed to zero on input and
//             output, quiet-NaN canonical result 0x7FC00000.
//  Ports    : clock      - rising-edge clock
//             reset      - synchronous active-high reset
//             dataa      - operand A (FP32)
//             datab      - operand B (FP32)
//             load       - start request, accepted only while busy = 0
//             clear      - synchronous abort, same effect as reset
//             result     - registered FP32 sum, held until next completion
//             nan        - result is the canonical quiet NaN
//             overflow   - finite operands rounded past max finite
//             underflow  - nonzero exact sum below 2^-126, flushed to zero
//             zero       - result is +0 or -0
//             busy       - operation in flight
//             done       - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add7_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int LATENCY     = 7,
  parameter int CYCLE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic                  load,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  nan,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  // Arithmetic occupies four registered stages (align, add, normalize,
  // round); the remaining stages up to LATENCY are a plain delay line.
  // LATENCY must therefore be at least 6.
  localparam int          DLY  = LATENCY - 5;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // --------------------------------------------------------------------------
  // Handshake, operand registers and result/flag registers
  // --------------------------------------------------------------------------
  logic [CYCLE_WIDTH-1:0] r_cnt;
  logic [31:0]            r_opa;
  logic [31:0]            r_opb;
  logic [35:0]            w_final;   // {sum, nan, overflow, underflow, zero}

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      nan       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (load) begin
          r_opa <= dataa;
          r_opb <= datab;
          r_cnt <= '0;
          busy  <= 1'b1;
        end
      end else if (r_cnt == CYCLE_WIDTH'(LATENCY - 1)) begin
        // Operands were captured LATENCY-1 edges ago, so the delay line
        // output now holds the finished sum for this operation.
        busy  <= 1'b0;
        done  <= 1'b1;
        r_cnt <= '0;
        {result, nan, overflow, underflow, zero} <= w_final;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: classify, order by magnitude, align the smaller operand
  // --------------------------------------------------------------------------
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [30:0] w_mag_a, w_mag_b;
  logic        w_a_big;
  logic [7:0]  w_big_exp, w_sml_exp, w_diff;
  logic [23:0] w_big_sig, w_sml_sig;
  logic        w_big_sign;
  logic [4:0]  w_sh;
  logic [26:0] w_sml_ext, w_sml_shr, w_sml_aln;
  logic        w_lost;
  logic        w_spec, w_spec_nan, w_spec_zero;
  logic [31:0] w_spec_val;

  assign w_a_nan  = (r_opa[30:23] == 8'hFF) && (r_opa[22:0] != 23'd0);
  assign w_b_nan  = (r_opb[30:23] == 8'hFF) && (r_opb[22:0] != 23'd0);
  assign w_a_inf  = (r_opa[30:23] == 8'hFF) && (r_opa[22:0] == 23'd0);
  assign w_b_inf  = (r_opb[30:23] == 8'hFF) && (r_opb[22:0] == 23'd0);
  // Exponent field 0 covers both true zeros and flushed denormals.
  assign w_a_zero = (r_opa[30:23] == 8'h00);
  assign w_b_zero = (r_opb[30:23] == 8'h00);

  assign w_mag_a  = w_a_zero ? 31'd0 : r_opa[30:0];
  assign w_mag_b  = w_b_zero ? 31'd0 : r_opb[30:0];
  assign w_a_big  = (w_mag_a >= w_mag_b);

  assign w_big_exp  = w_a_big ? r_opa[30:23] : r_opb[30:23];
  assign w_sml_exp  = w_a_big ? r_opb[30:23] : r_opa[30:23];
  assign w_big_sig  = w_a_big ? {~w_a_zero, r_opa[22:0] & {23{~w_a_zero}}}
                              : {~w_b_zero, r_opb[22:0] & {23{~w_b_zero}}};
  assign w_sml_sig  = w_a_big ? {~w_b_zero, r_opb[22:0] & {23{~w_b_zero}}}
                              : {~w_a_zero, r_opa[22:0] & {23{~w_a_zero}}};
  assign w_big_sign = w_a_big ? r_opa[31] : r_opb[31];

  // Three extra bits below the LSB (guard, round, sticky). Everything
  // shifted past the sticky position is ORed into it.
  assign w_diff    = w_big_exp - w_sml_exp;
  assign w_sh      = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
  assign w_sml_ext = {w_sml_sig, 3'b000};
  assign w_sml_shr = w_sml_ext >> w_sh;
  assign w_lost    = |(w_sml_ext & ~(27'h7FF_FFFF << w_sh));
  assign w_sml_aln = {w_sml_shr[26:1], w_sml_shr[0] | w_lost};

  // Results that bypass the arithmetic path.
  always_comb begin
    w_spec      = 1'b0;
    w_spec_val  = 32'd0;
    w_spec_nan  = 1'b0;
    w_spec_zero = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_opa[31] != r_opb[31]))) begin
      w_spec     = 1'b1;
      w_spec_val = QNAN;
      w_spec_nan = 1'b1;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {r_opa[31], 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {r_opb[31], 8'hFF, 23'd0};
    end else if (w_a_zero && w_b_zero) begin
      // Sum of two zeros is -0 only when both are negative.
      w_spec      = 1'b1;
      w_spec_val  = {r_opa[31] & r_opb[31], 31'd0};
      w_spec_zero = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3 combinational: leading-zero count and normalization
  // --------------------------------------------------------------------------
  logic        r2_spec, r2_spec_nan, r2_spec_zero, r2_sign;
  logic [31:0] r2_spec_val;
  logic [7:0]  r2_exp;
  logic [27:0] r2_sum;
  logic [4:0]  w_lzc;
  logic [26:0] w_norm;
  logic [9:0]  w_en;
  logic        w_cancel;

  always_comb begin
    w_lzc = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (r2_sum[i]) w_lzc = 5'(27 - i);
    end
  end

  always_comb begin
    w_norm = 27'd0;
    if (w_lzc == 5'd0) begin
      // Carry out of the add: shift right once, keep the dropped bit sticky.
      w_norm = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
    end else begin
      w_norm = 27'(r2_sum << (w_lzc - 5'd1));
    end
  end

  // Biased exponent of the normalized value; negative or zero means the
  // exact sum lies below the smallest normal.
  assign w_en     = {2'b00, r2_exp} + 10'd1 - {5'd0, w_lzc};
  assign w_cancel = !r2_spec && (r2_sum == 28'd0);

  // --------------------------------------------------------------------------
  // Stage 4 combinational: round to nearest even, pack, range checks
  // --------------------------------------------------------------------------
  logic        r3_spec, r3_spec_nan, r3_spec_zero, r3_sign;
  logic [31:0] r3_spec_val;
  logic [9:0]  r3_exp;
  logic [26:0] r3_norm;
  logic        w_rnd;
  logic [24:0] w_mant;
  logic [9:0]  w_ef;
  logic [22:0] w_frac;
  logic [35:0] w_s4;

  assign w_rnd  = r3_norm[2] & (r3_norm[3] | r3_norm[1] | r3_norm[0]);
  assign w_mant = {1'b0, r3_norm[26:3]} + {24'd0, w_rnd};
  // Rounding carry turns 1.111..1 into 10.000..0: bump the exponent.
  assign w_ef   = r3_exp + {9'd0, w_mant[24]};
  assign w_frac = w_mant[24] ? w_mant[23:1] : w_mant[22:0];

  always_comb begin
    w_s4 = 36'd0;
    if (r3_spec) begin
      w_s4 = {r3_spec_val, r3_spec_nan, 1'b0, 1'b0, r3_spec_zero};
    end else if (r3_exp[9] || (r3_exp == 10'd0)) begin
      w_s4 = {r3_sign, 31'd0, 4'b0011};
    end else if (w_ef >= 10'd255) begin
      w_s4 = {r3_sign, 8'hFF, 23'd0, 4'b0100};
    end else begin
      w_s4 = {r3_sign, w_ef[7:0], w_frac, 4'b0000};
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic        r1_spec, r1_spec_nan, r1_spec_zero, r1_sign, r1_sub;
  logic [31:0] r1_spec_val;
  logic [7:0]  r1_exp;
  logic [26:0] r1_big, r1_sml;
  logic [35:0] r4_out;
  logic [35:0] r_dly [DLY];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r1_spec      <= 1'b0;
      r1_spec_nan  <= 1'b0;
      r1_spec_zero <= 1'b0;
      r1_spec_val  <= '0;
      r1_sign      <= 1'b0;
      r1_sub       <= 1'b0;
      r1_exp       <= '0;
      r1_big       <= '0;
      r1_sml       <= '0;
      r2_spec      <= 1'b0;
      r2_spec_nan  <= 1'b0;
      r2_spec_zero <= 1'b0;
      r2_spec_val  <= '0;
      r2_sign      <= 1'b0;
      r2_exp       <= '0;
      r2_sum       <= '0;
      r3_spec      <= 1'b0;
      r3_spec_nan  <= 1'b0;
      r3_spec_zero <= 1'b0;
      r3_spec_val  <= '0;
      r3_sign      <= 1'b0;
      r3_exp       <= '0;
      r3_norm      <= '0;
      r4_out       <= '0;
      for (int i = 0; i < DLY; i++) r_dly[i] <= '0;
    end else begin
      // Stage 1
      r1_spec      <= w_spec;
      r1_spec_nan  <= w_spec_nan;
      r1_spec_zero <= w_spec_zero;
      r1_spec_val  <= w_spec_val;
      r1_sign      <= w_big_sign;
      r1_sub       <= r_opa[31] ^ r_opb[31];
      r1_exp       <= w_big_exp;
      r1_big       <= {w_big_sig, 3'b000};
      r1_sml       <= w_sml_aln;
      // Stage 2: the larger magnitude is always on the left, so the
      // difference never goes negative.
      r2_spec      <= r1_spec;
      r2_spec_nan  <= r1_spec_nan;
      r2_spec_zero <= r1_spec_zero;
      r2_spec_val  <= r1_spec_val;
      r2_sign      <= r1_sign;
      r2_exp       <= r1_exp;
      r2_sum       <= r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                             : ({1'b0, r1_big} + {1'b0, r1_sml});
      // Stage 3: exact cancellation becomes +0 regardless of operand signs.
      r3_spec      <= r2_spec | w_cancel;
      r3_spec_nan  <= r2_spec_nan;
      r3_spec_zero <= r2_spec_zero | w_cancel;
      r3_spec_val  <= r2_spec ? r2_spec_val : 32'd0;
      r3_sign      <= r2_sign;
      r3_exp       <= w_en;
      r3_norm      <= w_norm;
      // Stage 4 and delay line
      r4_out       <= w_s4;
      r_dly[0]     <= r4_out;
      for (int i = 1; i < DLY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_final = r_dly[DLY-1];

endmodule

`default_nettype wire

// File: tb/tb_fp_add7_unit.sv
// ============================================================================
//  Module   : tb_fp_add7_unit
//  Purpose  : Scoreboard bench for fp_add7_unit. A driver issues loads and
//             pushes the expected sum/flags (from an exact big-integer model)
//             into a queue; a monitor pops on every done pulse and compares
//             value, flags and completion cycle, and watches busy/hold.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add7_unit;

  localparam int LAT = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        load  = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [31:0] result;
  logic        nan, overflow, underflow, zero, busy, done;

  fp_add7_unit #(.DATA_WIDTH(32), .LATENCY(LAT), .CYCLE_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .dataa(dataa), .datab(datab),
    .load(load), .clear(clear), .result(result), .nan(nan),
    .overflow(overflow), .underflow(underflow), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [35:0] exp;
    int          due;
  } item_t;

  item_t       sb_q[$];
  logic [35:0] held = 36'd0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  // Exact reference: operands become integers in units of 2^-149, are summed
  // exactly, then rounded to 24 significant bits with ties-to-even.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, mag, q, rem, half, one;
    logic         sgn, an, bn, ai, bi, az, bz;
    int           p, sh, e;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn || (ai && bi && (a[31] != b[31]))) return {32'h7FC0_0000, 4'b1000};
    if (ai) return {a[31], 8'hFF, 23'd0, 4'b0000};
    if (bi) return {b[31], 8'hFF, 23'd0, 4'b0000};
    if (az && bz) return {a[31] & b[31], 31'd0, 4'b0001};
    one = 1;
    ma  = az ? 300'd0 : ({276'd0, 1'b1, a[22:0]} << (int'(a[30:23]) - 1));
    mb  = bz ? 300'd0 : ({276'd0, 1'b1, b[22:0]} << (int'(b[30:23]) - 1));
    if (a[31] == b[31]) begin
      mag = ma + mb; sgn = a[31];
    end else if (ma >= mb) begin
      mag = ma - mb; sgn = a[31];
    end else begin
      mag = mb - ma; sgn = b[31];
    end
    if (mag == 300'd0) return {32'd0, 4'b0001};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return {sgn, 31'd0, 4'b0011};
    sh  = p - 23;
    q   = mag >> sh;
    rem = mag - (q << sh);
    if (sh > 0) begin
      half = one << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    end
    e = p - 22;
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 4'b0100};
    return {sgn, 8'(e), q[22:0], 4'b0000};
  endfunction

  function automatic logic [31:0] rnd_fp(input int lo, input int hi);
    return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (done) begin
        n_checks += 2;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_at_done: busy=%b required 0 (cycle %0d)", busy, cyc);
        end
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: cycle %0d result=%h with nothing outstanding", cyc, result);
        end else begin
          item_t it;
          it = sb_q.pop_front();
          if ({result, nan, overflow, underflow, zero} !== it.exp) begin
            n_err++;
            $display("FAIL sum: a=%h b=%h got=%h flags(n,o,u,z)=%b required=%h flags=%b",
                     it.a, it.b, result, {nan, overflow, underflow, zero}, it.exp[35:4], it.exp[3:0]);
          end
          if (cyc != it.due) begin
            n_err++;
            $display("FAIL done_cycle: a=%h b=%h done at edge %0d required edge %0d", it.a, it.b, cyc, it.due);
          end
          held = it.exp;
        end
      end else begin
        n_checks += 2;
        if (busy !== (sb_q.size() != 0)) begin
          n_err++;
          $display("FAIL busy: cycle %0d busy=%b required %b", cyc, busy, sb_q.size() != 0);
        end
        if ({result, nan, overflow, underflow, zero} !== held) begin
          n_err++;
          $display("FAIL hold: cycle %0d got=%h/%b required=%h/%b", cyc, result,
                   {nan, overflow, underflow, zero}, held[35:4], held[3:0]);
        end
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    item_t it;
    int    waited = 0;
    while (busy === 1'b1 && waited < 40) begin
      @(posedge clock); #1;
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL issue_timeout: busy=%b required 0 after %0d cycles", busy, waited);
    end else begin
      dataa = a; datab = b; load = 1'b1;
      @(posedge clock); #1;
      load = 1'b0;
      it.a = a; it.b = b; it.exp = exp; it.due = cyc + LAT;
      sb_q.push_back(it);
      n_checks++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_at_accept: busy=%b required 1 (cycle %0d)", busy, cyc);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((busy === 1'b1 || done === 1'b1) && waited < 40) begin
      @(posedge clock); #1;
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  // Assert reset (or clear) now so it is sampled at the next edge.
  task automatic do_reset(input bit use_clear);
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; clear = 1'b0;
    sb_q.delete();
    held = 36'd0;
    n_checks++;
    if ({result, nan, overflow, underflow, zero, busy, done} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_state: got result=%h n,o,u,z,busy,done=%b required all 0",
               result, {nan, overflow, underflow, zero, busy, done});
    end
  endtask

  logic [31:0] specials [13] = '{
    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
    32'h7F80_0001, 32'h0000_0001, 32'h807F_FFFF, 32'h7F7F_FFFF, 32'hFF7F_FFFF,
    32'h0080_0000, 32'h8080_0000, 32'h3F80_0000
  };

  initial begin
    logic [31:0] a, b, t;
    int          eb, k;

    wait_cycles(3);
    do_reset(1'b0);
    mon_en = 1'b1;

    // Directed values with hand-derived expectations.
    issue(32'h3F80_0000, 32'h4000_0000, {32'h4040_0000, 4'b0000});
    issue(32'h3F80_0000, 32'hBF80_0000, {32'h0000_0000, 4'b0001});
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, {32'h7F80_0000, 4'b0100});
    issue(32'h7F80_0000, 32'hFF80_0000, {32'h7FC0_0000, 4'b1000});
    issue(32'h7FC0_0001, 32'h3F80_0000, {32'h7FC0_0000, 4'b1000});
    issue(32'h0080_0001, 32'h8080_0000, {32'h0000_0000, 4'b0011});
    issue(32'h0000_0001, 32'h3F80_0000, {32'h3F80_0000, 4'b0000});
    issue(32'h8000_0000, 32'h8000_0000, {32'h8000_0000, 4'b0001});
    issue(32'h7F80_0000, 32'h3F80_0000, {32'h7F80_0000, 4'b0000});
    issue(32'h3F80_0000, 32'h3380_0000, {32'h3F80_0000, 4'b0000}); // tie -> even
    issue(32'h3F80_0001, 32'h3380_0000, {32'h3F80_0002, 4'b0000}); // tie -> up
    wait_idle();

    // Load while busy is ignored.
    issue(32'h3F80_0000, 32'h4000_0000, {32'h4040_0000, 4'b0000});
    wait_cycles(2);
    dataa = 32'h4120_0000; datab = 32'h4120_0000; load = 1'b1;
    wait_cycles(1);
    load = 1'b0;
    wait_idle();

    // Reset at E3 aborts; new load at E4 completes at E11.
    issue(32'h4000_0000, 32'h4000_0000, {32'h4080_0000, 4'b0000});
    wait_cycles(2);
    do_reset(1'b0);
    issue(32'h3F80_0000, 32'h3F80_0000, {32'h4000_0000, 4'b0000});
    wait_idle();

    // Clear mid-operation, then clear racing a load.
    issue(32'h4040_0000, 32'h4040_0000, {32'h40C0_0000, 4'b0000});
    wait_cycles(4);
    do_reset(1'b1);
    dataa = 32'h3F80_0000; datab = 32'h3F80_0000; load = 1'b1; clear = 1'b1;
    wait_cycles(1);
    load = 1'b0; clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_vs_load: busy=%b required 0", busy);
    end
    wait_cycles(2);

    // Randomized operand pairs, back to back, with stray loads while busy.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          a  = rnd_fp(1, 254);
          eb = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
          b  = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        2: begin a = rnd_fp(1, 254); b = a ^ 32'h8000_0000; end
        3: begin
          a = specials[$urandom_range(0, 12)];
          b = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 12)] : rnd_fp(0, 255);
        end
        4: begin a = rnd_fp(0, 3); b = rnd_fp(0, 3); end
        5: begin a = rnd_fp(251, 254); b = rnd_fp(251, 254); b[31] = a[31]; end
        default: begin
          a = rnd_fp(100, 154);
          b = {~a[31], a[30:4], 4'($urandom)};
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
      issue(a, b, ref_add(a, b));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 7);
        wait_cycles(k - 1);
        dataa = $urandom; datab = $urandom; load = 1'b1;
        wait_cycles(1);
        load = 1'b0;
      end
    end
    wait_idle();
    wait_cycles(3);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL outstanding: %0d results never completed, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
